fdiv: RTL and testbench
=======================

# fdiv

Single-precision (IEEE-754 binary32) floating-point divider computing q = a / b with a registered result one clock after the operands are presented. It sits beside the FPU add/multiply units in the CPU execute stage and accepts a new operand pair every cycle. The op input selects the rounding mode. Invalid operations resolve to +1.0 so the block never emits NaN in the default build.

## Interface
- No parameters; widths fixed at 32-bit binary32.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  32  dividend, binary32.
- b  input  32  divisor, binary32.
- op  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward −inf, 11 toward +inf.
- q  output  32  quotient, binary32, registered.

## Operation
- Decode: sign s = a[31]^b[31]; exponent e = [30:23]; fraction f = [22:0].
- Class:
  - e=FF, f≠0 is NaN.
  - e=FF, f=0 is inf.
  - e=0 is zero; denormals are flushed to zero on input.
- Special results, checked in priority order:
  - any NaN operand → +1.0 (0x3F800000).
  - 0/0 → 0x3F800000.
  - inf/inf → 0x3F800000.
  - x/0 (x nonzero) → {s, 0xFF, 0}.
  - inf/x → {s, 0xFF, 0}.
  - 0/x → {s, 0}.
  - x/inf → {s, 0}.
- Normal path:
  - Mantissas ma = {1, fa}, mb = {1, fb}.
  - Quotient = (ma << 26) / mb: 27 quotient bits plus a nonzero-remainder sticky bit.
  - If quotient bit 26 = 0, shift left by 1 and decrement exponent.
  - Biased exponent E = ea − eb + 127 (− 1 if normalised by shift). Use 10-bit signed arithmetic.
- Rounding uses the guard bit plus sticky (round bit OR remainder≠0):
  - RNE: round up if guard & (sticky | lsb).
  - RTZ: never round up.
  - RDN: round up if s & (guard|sticky).
  - RUP: round up if !s & (guard|sticky).
  - A mantissa carry-out increments E.
- Overflow (E ≥ 255 after rounding):
  - RNE → ±inf.
  - RTZ → ±max finite (0x7F7FFFFF with sign).
  - RDN → −inf if negative, else +max finite.
  - RUP → +inf if positive, else −max finite.
- Underflow (E ≤ 0) → signed zero (flush, no denormal output).
- No exception flags are produced.

## Timing
- Fully pipelined, latency 1: q at edge n+1 reflects a, b, op sampled at edge n. Throughput is one result per cycle.
- Datapath from the operands to the q register is combinational.
- rst_n low: q = 0x00000000 immediately, asynchronously; held while low.
- Deassertion mid-stream: the first rising edge after release loads the result of the operands present at that edge.
- The op value is sampled with a and b at the same edge.

## Configuration
- FDIV_IEEE_NAN_EN defined:
  - NaN operands, 0/0 and inf/inf return canonical quiet NaN 0x7FC00000.
  - A NaN result is unsigned, regardless of s.
- FDIV_IEEE_NAN_EN undefined (default): these cases return 0x3F800000 as in Operation.

## Structure
- Package fdiv_pkg:
  - rounding-mode typedef (RM_RNE, RM_RTZ, RM_RDN, RM_RUP).
  - constants FP_ONE=0x3F800000, FP_QNAN=0x7FC00000, FP_INF_EXP=8'hFF, FP_BIAS=127, FP_MAX_FINITE=0x7F7FFFFF.
- Sub-module fdiv_mant_div: combinational restoring divider.
  - inputs: 24-bit ma, mb.
  - outputs: 27-bit quotient and sticky.
- Top fdiv handles classification, exponent, rounding, special-case muxing and the output register.

## Test plan
- Finite divides (RNE):
  - 0x3F800000/0x3F800000 → 0x3F800000.
  - 0x3F800000/0x3F000000 → 0x40000000.
- Rounding paths (RNE):
  - 0x40490FDB/0x402DF854 (π/e) → 0x3F93EEE0.
  - 0x402DF854/0x40490FDB → 0x3F5D816A.
- NaN operands:
  - a=0x3F800000, b=0xFFFFFACE → 0x3F800000.
  - a=0xFFFFFACE, b=0x3F800000 → 0x3F800000.
  - a=0xFFFFFACE, b=0xFFFFBEEF → 0x3F800000.
  - With FDIV_IEEE_NAN_EN, each of these → 0x7FC00000.
- Zeros:
  - 0x00000000/0x3F800000 → 0x00000000.
  - 0x3F800000/0x00000000 → 0x7F800000.
  - 0x00000000/0x00000000 → 0x3F800000.
- Rounding modes and overflow:
  - 0x7F7FFFFF/0x3F000000: op=00 → 0x7F800000; op=01 → 0x7F7FFFFF.
  - 0x3F800000/0x40400000: op=00 → 0x3EAAAAAB; op=01 → 0x3EAAAAAA.
- Timing and reset:
  - New operands every 10 ns; each q is checked exactly one cycle after its operands are applied.
  - rst_n pulsed low mid-stream → q=0 asynchronously.
  - Correct results resume on the first edge after release.

Source files
------------

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types and constants for the binary32 divider.
//   rm_e    : rounding-mode encoding carried on op
//   fp32_t  : binary32 field view {sign, exp, frac}
//   FP_*    : encoding constants used by classification and result muxing
package fdiv_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXPF_W = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned MRND_W = 25;
    localparam int unsigned QUO_W  = 27;
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned RM_W   = 2;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXPF_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    localparam logic [FP_W-1:0]   FP_ONE        = 32'h3F80_0000;
    localparam logic [FP_W-1:0]   FP_QNAN       = 32'h7FC0_0000;
    localparam logic [FP_W-1:0]   FP_MAX_FINITE = 32'h7F7F_FFFF;
    localparam logic [EXPF_W-1:0] FP_INF_EXP    = 8'hFF;
    localparam int unsigned       FP_BIAS       = 127;

    // Signed infinity / zero / max-finite builders for the result mux.
    function automatic logic [FP_W-1:0] fp_inf(input logic sign);
        return {sign, FP_INF_EXP, FRAC_W'(0)};
    endfunction

    function automatic logic [FP_W-1:0] fp_zero(input logic sign);
        return {sign, (FP_W-1)'(0)};
    endfunction

    function automatic logic [FP_W-1:0] fp_max(input logic sign);
        return {sign, FP_MAX_FINITE[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fdiv_if.sv
// fdiv_if: operand/result bundle for the divider.
//   a, b : binary32 dividend / divisor
//   op   : rounding mode (rm_e encoding)
//   q    : registered binary32 quotient
// master drives operands, slave (the divider) drives q.
interface fdiv_if;
    import fdiv_pkg::*;

    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [RM_W-1:0] op;
    logic [FP_W-1:0] q;

    modport master (output a, output b, output op, input q);
    modport slave  (input a, input b, input op, output q);
endinterface

// File: rtl/fdiv_mant_div.sv
// fdiv_mant_div: combinational restoring divider, (ma << 26) / mb.
//   i_ma, i_mb  : 24-bit mantissas with hidden bit set
//   o_quo_c     : 27 quotient bits (bit 26 set when ma >= mb)
//   o_sticky_c  : final remainder is nonzero
module fdiv_mant_div
    import fdiv_pkg::*;
(
    input  logic [MANT_W-1:0] i_ma,
    input  logic [MANT_W-1:0] i_mb,
    output logic [QUO_W-1:0]  o_quo_c,
    output logic              o_sticky_c
);

    // Partial remainder stays below 2*mb, so one extra bit suffices.
    logic [MANT_W:0] w_rem;

    always_comb begin
        o_quo_c = '0;
        w_rem   = {1'b0, i_ma};
        for (int i = int'(QUO_W) - 1; i >= 0; i--) begin
            if (i != int'(QUO_W) - 1) begin
                w_rem = {w_rem[MANT_W-1:0], 1'b0};
            end
            if (w_rem >= {1'b0, i_mb}) begin
                o_quo_c[i] = 1'b1;
                w_rem      = w_rem - {1'b0, i_mb};
            end
        end
        o_sticky_c = |w_rem;
    end

endmodule

// File: rtl/fdiv.sv
// fdiv: binary32 divider q = a / b, one-cycle latency, one result per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   bus   : fdiv_if.slave carrying a, b, op in and q out
// Denormal inputs flush to zero; tiny results flush to signed zero.
// Build option FDIV_IEEE_NAN_EN: invalid cases (NaN operand, 0/0, inf/inf)
// return quiet NaN 0x7FC00000 instead of +1.0.
module fdiv
    import fdiv_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    fdiv_if.slave bus
);

`ifdef FDIV_IEEE_NAN_EN
    localparam logic [FP_W-1:0] INVALID_RES = FP_QNAN;
`else
    localparam logic [FP_W-1:0] INVALID_RES = FP_ONE;
`endif

    fp32_t             w_a;
    fp32_t             w_b;
    rm_e               w_rm;
    logic              w_sign;
    logic              w_a_nan, w_a_inf, w_a_zero;
    logic              w_b_nan, w_b_inf, w_b_zero;
    logic [MANT_W-1:0] w_ma, w_mb;
    logic [QUO_W-1:0]  w_quo;
    logic              w_rem_nz;
    logic              w_norm_shift;
    logic [MANT_W-1:0] w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_inexact;
    logic              w_round_up;
    logic [MRND_W-1:0] w_mant_rnd;
    logic [EXP_W-1:0]  w_exp_pre;
    logic [EXP_W-1:0]  w_exp_rnd;
    logic              w_ovf, w_unf;
    logic [FP_W-1:0]   w_norm_res;
    logic [FP_W-1:0]   w_res;
    logic [FP_W-1:0]   r_q;

    assign w_a    = bus.a;
    assign w_b    = bus.b;
    assign w_rm   = rm_e'(bus.op);
    assign w_sign = w_a.sign ^ w_b.sign;

    // Operand classes; exp==0 covers true zero and flushed denormals.
    assign w_a_nan  = (w_a.exp == FP_INF_EXP) && (w_a.frac != '0);
    assign w_a_inf  = (w_a.exp == FP_INF_EXP) && (w_a.frac == '0);
    assign w_a_zero = (w_a.exp == '0);
    assign w_b_nan  = (w_b.exp == FP_INF_EXP) && (w_b.frac != '0);
    assign w_b_inf  = (w_b.exp == FP_INF_EXP) && (w_b.frac == '0);
    assign w_b_zero = (w_b.exp == '0);

    assign w_ma = {1'b1, w_a.frac};
    assign w_mb = {1'b1, w_b.frac};

    fdiv_mant_div u_mant_div (
        .i_ma       (w_ma),
        .i_mb       (w_mb),
        .o_quo_c    (w_quo),
        .o_sticky_c (w_rem_nz)
    );

    // Normalise, round and range-check the finite quotient.
    always_comb begin
        w_norm_shift = ~w_quo[QUO_W-1];
        w_mant       = w_quo[QUO_W-1:3];
        w_guard      = w_quo[2];
        w_sticky     = (|w_quo[1:0]) | w_rem_nz;
        if (w_norm_shift) begin
            w_mant   = w_quo[QUO_W-2:2];
            w_guard  = w_quo[1];
            w_sticky = w_quo[0] | w_rem_nz;
        end

        // Modular 10-bit math; the top bit acts as the sign of E.
        w_exp_pre = EXP_W'(w_a.exp) - EXP_W'(w_b.exp) + EXP_W'(FP_BIAS)
                  - EXP_W'(w_norm_shift);

        w_inexact  = w_guard | w_sticky;
        w_round_up = 1'b0;
        case (w_rm)
            RM_RNE:  w_round_up = w_guard & (w_sticky | w_mant[0]);
            RM_RTZ:  w_round_up = 1'b0;
            RM_RDN:  w_round_up = w_sign & w_inexact;
            RM_RUP:  w_round_up = ~w_sign & w_inexact;
            default: w_round_up = 1'b0;
        endcase

        // A carry out leaves 2^24, whose low fraction bits are already zero.
        w_mant_rnd = {1'b0, w_mant} + MRND_W'(w_round_up);
        w_exp_rnd  = w_exp_pre + EXP_W'(w_mant_rnd[MANT_W]);

        w_ovf = ~w_exp_rnd[EXP_W-1] && (w_exp_rnd >= EXP_W'(FP_INF_EXP));
        w_unf = w_exp_rnd[EXP_W-1] || (w_exp_rnd == '0);

        w_norm_res = {w_sign, w_exp_rnd[EXPF_W-1:0], w_mant_rnd[FRAC_W-1:0]};
        if (w_ovf) begin
            case (w_rm)
                RM_RNE:  w_norm_res = fp_inf(w_sign);
                RM_RTZ:  w_norm_res = fp_max(w_sign);
                RM_RDN:  w_norm_res = w_sign ? fp_inf(w_sign) : fp_max(w_sign);
                RM_RUP:  w_norm_res = w_sign ? fp_max(w_sign) : fp_inf(w_sign);
                default: w_norm_res = fp_inf(w_sign);
            endcase
        end else if (w_unf) begin
            w_norm_res = fp_zero(w_sign);
        end
    end

    // Special-case priority mux ahead of the output register.
    always_comb begin
        w_res = w_norm_res;
        if (w_a_nan || w_b_nan) begin
            w_res = INVALID_RES;
        end else if (w_a_zero && w_b_zero) begin
            w_res = INVALID_RES;
        end else if (w_a_inf && w_b_inf) begin
            w_res = INVALID_RES;
        end else if (w_b_zero || w_a_inf) begin
            w_res = fp_inf(w_sign);
        end else if (w_a_zero || w_b_inf) begin
            w_res = fp_zero(w_sign);
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_res;
        end
    end

    assign bus.q = r_q;

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: self-checking bench for fdiv. Directed vectors plus randomized
// operands compared against an integer-arithmetic reference model; q is
// checked one cycle after its operands, with a mid-stream reset pulse.
module tb_fdiv;

`ifdef FDIV_IEEE_NAN_EN
    localparam logic [31:0] EXP_INVALID = 32'h7FC0_0000;
`else
    localparam logic [31:0] EXP_INVALID = 32'h3F80_0000;
`endif

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    logic [31:0] exp_pending;
    string       tag_pending;
    bit          have_pending;

    fdiv_if u_if ();

    fdiv u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: exact quotient via 64-bit integer division, then IEEE rounding
    // by comparing the discarded part against one half.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic s;
        int ea, eb, e, sh;
        bit a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        longint unsigned num, den, quo, mant, disc, half;
        bit rem_nz, above, tie, inexact, up;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        a_zero = (ea == 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return EXP_INVALID;
        if (b_zero || a_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_inf) return {s, 31'h0};
        num    = 64'({1'b1, a[22:0]}) << 40;
        den    = 64'({1'b1, b[22:0]});
        quo    = num / den;
        rem_nz = (num % den) != 0;
        sh     = (quo >= (64'd1 << 40)) ? 17 : 16;
        e      = ea - eb + 127 - ((sh == 16) ? 1 : 0);
        mant   = quo >> sh;
        disc   = quo & ((64'd1 << sh) - 1);
        half   = 64'd1 << (sh - 1);
        above  = (disc > half) || ((disc == half) && rem_nz);
        tie    = (disc == half) && !rem_nz;
        inexact = (disc != 0) || rem_nz;
        case (op)
            2'b00:   up = above || (tie && mant[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = s && inexact;
            default: up = !s && inexact;
        endcase
        if (up) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) begin
            case (op)
                2'b00:   return {s, 8'hFF, 23'h0};
                2'b01:   return {s, 31'h7F7FFFFF};
                2'b10:   return s ? {s, 8'hFF, 23'h0} : {s, 31'h7F7FFFFF};
                default: return s ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0};
            endcase
        end
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'h00;
            1:       v[30:23] = 8'hFF;
            2:       begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
            3, 4:    v[30:23] = 8'($urandom_range(230, 254));
            5, 6:    v[30:23] = 8'($urandom_range(1, 30));
            7:       begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = 23'h0; end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Checks the previous operands' result, then applies the next pair.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input string tag);
        @(posedge clk);
        #1;
        if (have_pending) check_val(tag_pending, u_if.q, exp_pending);
        u_if.a       = a;
        u_if.b       = b;
        u_if.op      = op;
        exp_pending  = exp;
        tag_pending  = tag;
        have_pending = 1'b1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        n_total      = 0;
        n_bad        = 0;
        have_pending = 1'b0;
        rst_n        = 1'b0;
        u_if.a       = 32'h3F80_0000;
        u_if.b       = 32'h3F80_0000;
        u_if.op      = 2'b00;
        #2;
        check_val("reset_q", u_if.q, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        step(32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000, "one_div_one");
        step(32'h3F800000, 32'h3F000000, 2'b00, 32'h40000000, "one_div_half");
        step(32'h40490FDB, 32'h402DF854, 2'b00, 32'h3F93EEE0, "pi_div_e");
        step(32'h402DF854, 32'h40490FDB, 2'b00, 32'h3F5D816A, "e_div_pi");
        step(32'h3F800000, 32'hFFFFFACE, 2'b00, EXP_INVALID,  "nan_b");
        step(32'hFFFFFACE, 32'h3F800000, 2'b00, EXP_INVALID,  "nan_a");
        step(32'hFFFFFACE, 32'hFFFFBEEF, 2'b00, EXP_INVALID,  "nan_ab");
        step(32'h00000000, 32'h3F800000, 2'b00, 32'h00000000, "zero_div_x");
        step(32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, "x_div_zero");
        step(32'h00000000, 32'h00000000, 2'b00, EXP_INVALID,  "zero_div_zero");
        step(32'h7F800000, 32'hFF800000, 2'b00, EXP_INVALID,  "inf_div_inf");
        step(32'hFF800000, 32'h3F800000, 2'b00, 32'hFF800000, "ninf_div_x");
        step(32'h3F800000, 32'hFF800000, 2'b00, 32'h80000000, "x_div_ninf");
        step(32'h7F7FFFFF, 32'h3F000000, 2'b00, 32'h7F800000, "ovf_rne");
        step(32'h7F7FFFFF, 32'h3F000000, 2'b01, 32'h7F7FFFFF, "ovf_rtz");
        step(32'hFF7FFFFF, 32'h3F000000, 2'b10, 32'hFF800000, "ovf_rdn_neg");
        step(32'h7F7FFFFF, 32'h3F000000, 2'b10, 32'h7F7FFFFF, "ovf_rdn_pos");
        step(32'hFF7FFFFF, 32'h3F000000, 2'b11, 32'hFF7FFFFF, "ovf_rup_neg");
        step(32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, "third_rne");
        step(32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, "third_rtz");
        step(32'hBF800000, 32'h40400000, 2'b10, 32'hBEAAAAAB, "third_rdn_neg");
        step(32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAB, "third_rup");
        step(32'h00800000, 32'h7F000000, 2'b11, 32'h00000000, "unf_flush");
        step(32'h00400000, 32'h3F800000, 2'b00, 32'h00000000, "denorm_in");

        for (int i = 0; i < 150; i++) begin
            ra  = rand_fp();
            rb  = rand_fp();
            rop = 2'($urandom_range(0, 3));
            step(ra, rb, rop, ref_div(ra, rb, rop), "rand_a");
        end

        // Mid-stream reset: q clears asynchronously, holds, then resumes.
        @(posedge clk);
        #1;
        if (have_pending) check_val(tag_pending, u_if.q, exp_pending);
        have_pending = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", u_if.q, 32'h0);
        @(posedge clk);
        #1;
        check_val("rst_hold", u_if.q, 32'h0);
        u_if.a       = 32'h3F800000;
        u_if.b       = 32'h40400000;
        u_if.op      = 2'b00;
        exp_pending  = 32'h3EAAAAAB;
        tag_pending  = "first_after_rst";
        have_pending = 1'b1;
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 250; i++) begin
            ra  = rand_fp();
            rb  = rand_fp();
            rop = 2'($urandom_range(0, 3));
            step(ra, rb, rop, ref_div(ra, rb, rop), "rand_b");
        end

        @(posedge clk);
        #1;
        if (have_pending) check_val(tag_pending, u_if.q, exp_pending);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
